// File: rtl/holly_pkg.sv
// ---------------------------------------------------------------------------
// holly_pkg
// Shared definitions for the Holly data-memory responder and the address
// decoder: region bounds in the 29-bit physical space, FSM state and region
// enumerations, the error fill word and a range helper.
// ---------------------------------------------------------------------------
package holly_pkg;

  // Inclusive region bounds, 29-bit physical addresses.
  localparam logic [28:0] PVR_BASE    = 29'h005F_7C00;
  localparam logic [28:0] PVR_LIMIT   = 29'h005F_7CFF;
  localparam logic [28:0] VRAM_BASE   = 29'h0400_0000;
  localparam logic [28:0] VRAM_LIMIT  = 29'h047F_FFFF;
  localparam logic [28:0] SDRAM_BASE  = 29'h0C00_0000;
  localparam logic [28:0] SDRAM_LIMIT = 29'h0CFF_FFFF;

  // Read data returned when a memory access times out.
  localparam logic [63:0] ERR_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PVR_STB  = 3'd1,
    ST_PVR_DATA = 3'd2,
    ST_MEM_REQ  = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    REG_PVR      = 2'd0,
    REG_VRAM     = 2'd1,
    REG_SDRAM    = 2'd2,
    REG_UNMAPPED = 2'd3
  } region_e;

  function automatic logic in_region(input logic [28:0] addr,
                                     input logic [28:0] lo,
                                     input logic [28:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/holly_addr_decode.sv
// ---------------------------------------------------------------------------
// holly_addr_decode
// Purely combinational decode of a 29-bit physical address into a target
// region and a 24-bit byte offset inside that target.
//   addr   in  29 : physical address
//   region out    : REG_PVR / REG_VRAM / REG_SDRAM / REG_UNMAPPED
//   offset out 24 : byte offset (VRAM uses bits [22:0], SDRAM bits [23:0])
// ---------------------------------------------------------------------------
module holly_addr_decode
  import holly_pkg::*;
(
  input  logic [28:0] addr,
  output region_e     region,
  output logic [23:0] offset
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    region = REG_UNMAPPED;
    offset = '0;
    if (in_region(addr, PVR_BASE, PVR_LIMIT)) begin
      region = REG_PVR;
      offset = addr[23:0];
    end else if (in_region(addr, VRAM_BASE, VRAM_LIMIT)) begin
      region = REG_VRAM;
      offset = {1'b0, addr[22:0]};
    end else if (in_region(addr, SDRAM_BASE, SDRAM_LIMIT)) begin
      region = REG_SDRAM;
      offset = addr[23:0];
    end
  end

endmodule

// File: rtl/holly_dm_responder.sv
// ---------------------------------------------------------------------------
// holly_dm_responder
// Target-side responder for the SH4 data-memory request interface. Accepts
// one request at a time, decodes it and forwards it to the PVR register
// port, the 64-bit memory port (VRAM/SDRAM) or an unmapped sink, then
// returns a one-cycle dm_resp_valid with read data.
//   clk, rst                     : clock, async active-high reset
//   dm_req_*                     : request from the core (held until response)
//   dm_resp_rdata/valid          : completion pulse and held read data
//   pvr_reg_cs/rd/wr/addr/din    : PVR register strobes (one cycle)
//   pvr_dout                     : PVR read data, valid the cycle after pvr_rd
//   mem_*                        : valid/ready memory request + read return
//   err_clr, err_unmapped/timeout, err_addr : sticky error reporting
// Every output comes from a register or from decoded registered state.
// ---------------------------------------------------------------------------
module holly_dm_responder
  import holly_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic        pvr_reg_cs,
  output logic        pvr_rd,
  output logic        pvr_wr,
  output logic [15:0] pvr_addr,
  output logic [31:0] pvr_din,
  input  logic [31:0] pvr_dout,
  output logic [23:0] mem_addr,
  output logic        mem_sel,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        err_clr,
  output logic        err_unmapped,
  output logic        err_timeout,
  output logic [28:0] err_addr
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state;
  logic [28:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        wen_q;
  logic        mem_sel_q;
  logic [23:0] offset_q;
  logic [7:0]  tmo_cnt;
  logic [63:0] rdata_q;

  region_e     dec_region;
  logic [23:0] dec_offset;
  logic        unmapped_hit;
  logic        timeout_hit;

  // Only the low 29 bits form the physical address.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^dm_req_addr[31:29];

  holly_addr_decode u_decode (
    .addr   (dm_req_addr[28:0]),
    .region (dec_region),
    .offset (dec_offset)
  );

  // A handshake completing in the same cycle the counter expires wins over
  // the timeout: the memory has already taken the request.
  always_comb begin
    unmapped_hit = (state == ST_IDLE) && dm_req_valid && (dec_region == REG_UNMAPPED);
    timeout_hit  = (tmo_cnt == TIMEOUT_CNT) &&
                   (((state == ST_MEM_REQ)  && !mem_ready) ||
                    ((state == ST_MEM_WAIT) && !mem_rvalid));
  end

  // NOTE: the request payload registers are reset too, because they drive
  // outputs directly and every output must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      wen_q     <= 1'b0;
      mem_sel_q <= 1'b0;
      offset_q  <= '0;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (dm_req_valid) begin
            addr_q    <= dm_req_addr[28:0];
            wdata_q   <= dm_req_wdata;
            wmask_q   <= dm_req_wmask;
            wen_q     <= dm_req_wen;
            mem_sel_q <= (dec_region == REG_SDRAM);
            offset_q  <= dec_offset;
            tmo_cnt   <= '0;
            case (dec_region)
              REG_PVR:             state <= ST_PVR_STB;
              REG_VRAM, REG_SDRAM: state <= ST_MEM_REQ;
              default: begin
                rdata_q <= '0;
                state   <= ST_RESP;
              end
            endcase
          end
        end
        ST_PVR_STB: state <= ST_PVR_DATA;
        ST_PVR_DATA: begin
          if (!wen_q) rdata_q <= {pvr_dout, pvr_dout};
          state <= ST_RESP;
        end
        ST_MEM_REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_ready) begin
            state <= wen_q ? ST_RESP : ST_MEM_WAIT;
          end else if (timeout_hit) begin
            rdata_q <= ERR_FILL;
            state   <= ST_RESP;
          end
        end
        ST_MEM_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state   <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q <= ERR_FILL;
            state   <= ST_RESP;
          end
        end
        // The held request is deliberately not looked at here.
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_unmapped <= 1'b0;
      err_timeout  <= 1'b0;
      err_addr     <= '0;
    end else begin
      err_unmapped <= unmapped_hit | (err_unmapped & ~err_clr);
      err_timeout  <= timeout_hit  | (err_timeout  & ~err_clr);
      if (unmapped_hit)     err_addr <= dm_req_addr[28:0];
      else if (timeout_hit) err_addr <= addr_q;
    end
  end

  assign dm_resp_valid = (state == ST_RESP);
  assign dm_resp_rdata = rdata_q;

  assign pvr_reg_cs = (state == ST_PVR_STB);
  assign pvr_rd     = pvr_reg_cs & ~wen_q;
  assign pvr_wr     = pvr_reg_cs &  wen_q;
  assign pvr_addr   = addr_q[15:0];
  assign pvr_din    = addr_q[2] ? wdata_q[63:32] : wdata_q[31:0];

  assign mem_valid = (state == ST_MEM_REQ);
  assign mem_addr  = offset_q;
  assign mem_sel   = mem_sel_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_wen   = wen_q;

endmodule

// File: tb/tb_holly_dm_responder.sv
// ---------------------------------------------------------------------------
// tb_holly_dm_responder
// Directed bench for holly_dm_responder. A default-parameter instance takes
// most traffic; a second instance with TIMEOUT=4 has its own request valid
// and is used for the timeout scenario. Inputs change and outputs are
// sampled on the falling edge; "cycle n" is the n-th falling edge after the
// rising edge that first samples dm_req_valid.
// ---------------------------------------------------------------------------
module tb_holly_dm_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dm_req_addr = '0;
  logic [63:0] dm_req_wdata = '0;
  logic [7:0]  dm_req_wmask = '0;
  logic        dm_req_wen = 1'b0;
  logic        dm_req_valid = 1'b0;
  logic        dm_req_valid_t = 1'b0;
  logic [31:0] pvr_dout = '0;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        err_clr = 1'b0;

  logic [63:0] dm_resp_rdata, dm_resp_rdata_t;
  logic        dm_resp_valid, dm_resp_valid_t;
  logic        pvr_reg_cs, pvr_rd, pvr_wr, pvr_reg_cs_t, pvr_rd_t, pvr_wr_t;
  logic [15:0] pvr_addr, pvr_addr_t;
  logic [31:0] pvr_din, pvr_din_t;
  logic [23:0] mem_addr, mem_addr_t;
  logic        mem_sel, mem_sel_t;
  logic [63:0] mem_wdata, mem_wdata_t;
  logic [7:0]  mem_wmask, mem_wmask_t;
  logic        mem_wen, mem_wen_t, mem_valid, mem_valid_t;
  logic        err_unmapped, err_timeout, err_unmapped_t, err_timeout_t;
  logic [28:0] err_addr, err_addr_t;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  always #5 clk = ~clk;

  holly_dm_responder dut (
    .clk(clk), .rst(rst),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_req_wmask(dm_req_wmask), .dm_req_wen(dm_req_wen),
    .dm_req_valid(dm_req_valid),
    .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
    .pvr_reg_cs(pvr_reg_cs), .pvr_rd(pvr_rd), .pvr_wr(pvr_wr),
    .pvr_addr(pvr_addr), .pvr_din(pvr_din), .pvr_dout(pvr_dout),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .err_clr(err_clr), .err_unmapped(err_unmapped),
    .err_timeout(err_timeout), .err_addr(err_addr)
  );

  holly_dm_responder #(.TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_req_wmask(dm_req_wmask), .dm_req_wen(dm_req_wen),
    .dm_req_valid(dm_req_valid_t),
    .dm_resp_rdata(dm_resp_rdata_t), .dm_resp_valid(dm_resp_valid_t),
    .pvr_reg_cs(pvr_reg_cs_t), .pvr_rd(pvr_rd_t), .pvr_wr(pvr_wr_t),
    .pvr_addr(pvr_addr_t), .pvr_din(pvr_din_t), .pvr_dout(pvr_dout),
    .mem_addr(mem_addr_t), .mem_sel(mem_sel_t), .mem_wdata(mem_wdata_t),
    .mem_wmask(mem_wmask_t), .mem_wen(mem_wen_t), .mem_valid(mem_valid_t),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .err_clr(err_clr), .err_unmapped(err_unmapped_t),
    .err_timeout(err_timeout_t), .err_addr(err_addr_t)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] a, input logic [63:0] wd, input logic w);
    dm_req_addr  = a;
    dm_req_wdata = wd;
    dm_req_wmask = 8'hFF;
    dm_req_wen   = w;
    dm_req_valid = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_resp_valid", 64'(dm_resp_valid), 64'd0);
    check("rst_resp_rdata", dm_resp_rdata, 64'd0);
    check("rst_err_unmapped", 64'(err_unmapped), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_err_addr", 64'(err_addr), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_pvr_cs", 64'(pvr_reg_cs), 64'd0);
    check("rst_mem_sel", 64'(mem_sel), 64'd0);
    rst = 1'b0;
    tick();

    // ---------------- PVR read ----------------
    pvr_dout = 32'h1234_5678;
    req(32'h005F_7C40, 64'd0, 1'b0);
    tick(); // cycle 1
    check("pvr_rd_c1", 64'(pvr_rd), 64'd1);
    check("pvr_cs_c1", 64'(pvr_reg_cs), 64'd1);
    check("pvr_wr_c1", 64'(pvr_wr), 64'd0);
    check("pvr_addr_c1", 64'(pvr_addr), 64'h7C40);
    check("pvr_rd_resp_c1", 64'(dm_resp_valid), 64'd0);
    tick(); // cycle 2
    check("pvr_rd_c2", 64'(pvr_rd), 64'd0);
    check("pvr_rd_resp_c2", 64'(dm_resp_valid), 64'd0);
    tick(); // cycle 3
    check("pvr_rd_resp_c3", 64'(dm_resp_valid), 64'd1);
    check("pvr_rd_rdata", dm_resp_rdata, 64'h1234_5678_1234_5678);
    dm_req_valid = 1'b0;
    tick();
    check("pvr_rd_resp_once", 64'(dm_resp_valid), 64'd0);

    // ---------------- PVR write ----------------
    req(32'h005F_7C44, 64'hAAAA_0000_5555_0000, 1'b1);
    tick(); // cycle 1
    check("pvr_wr_c1", 64'(pvr_wr), 64'd1);
    check("pvr_wr_rd_c1", 64'(pvr_rd), 64'd0);
    check("pvr_din", 64'(pvr_din), 64'hAAAA_0000);
    tick(); // cycle 2
    check("pvr_wr_c2", 64'(pvr_wr), 64'd0);
    tick(); // cycle 3
    check("pvr_wr_resp_c3", 64'(dm_resp_valid), 64'd1);
    check("pvr_wr_rdata_held", dm_resp_rdata, 64'h1234_5678_1234_5678);
    dm_req_valid = 1'b0;
    tick();

    // ---------------- SDRAM read, slow ready ----------------
    mem_ready = 1'b0;
    req(32'h0C00_1000, 64'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("sd_mem_valid_wait", 64'(mem_valid), 64'd1);
      check("sd_resp_wait", 64'(dm_resp_valid), 64'd0);
    end
    check("sd_mem_sel", 64'(mem_sel), 64'd1);
    check("sd_mem_addr", 64'(mem_addr), 64'h00_1000);
    check("sd_mem_wen", 64'(mem_wen), 64'd0);
    mem_ready = 1'b1; // sampled at the end of cycle 4
    tick(); // cycle 5
    mem_ready = 1'b0;
    check("sd_mem_valid_c5", 64'(mem_valid), 64'd0);
    check("sd_resp_c5", 64'(dm_resp_valid), 64'd0);
    tick(); // cycle 6
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0123_4567_89AB_CDEF;
    check("sd_mem_valid_c6", 64'(mem_valid), 64'd0);
    tick(); // cycle 7
    mem_rvalid = 1'b0;
    check("sd_resp_c7", 64'(dm_resp_valid), 64'd1);
    check("sd_rdata", dm_resp_rdata, 64'h0123_4567_89AB_CDEF);
    check("sd_mem_valid_c7", 64'(mem_valid), 64'd0);
    dm_req_valid = 1'b0;
    tick();
    check("sd_mem_valid_after", 64'(mem_valid), 64'd0);

    // ---------------- unmapped read + err_clr ----------------
    req(32'h1F00_0000, 64'd0, 1'b0);
    tick(); // cycle 1
    check("um_resp_c1", 64'(dm_resp_valid), 64'd1);
    check("um_rdata", dm_resp_rdata, 64'd0);
    check("um_flag", 64'(err_unmapped), 64'd1);
    check("um_err_addr", 64'(err_addr), 64'h1F00_0000);
    dm_req_valid = 1'b0;
    tick();
    check("um_no_reaccept", 64'(dm_resp_valid), 64'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("um_flag_cleared", 64'(err_unmapped), 64'd0);

    // New error together with err_clr: the error wins. Just past PVR window.
    err_clr = 1'b1;
    req(32'h005F_7D00, 64'd0, 1'b0);
    tick();
    err_clr = 1'b0;
    check("um_err_wins", 64'(err_unmapped), 64'd1);
    check("um_edge_addr", 64'(err_addr), 64'h005F_7D00);
    check("um_edge_resp", 64'(dm_resp_valid), 64'd1);
    dm_req_valid = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // ---------------- VRAM write, same-cycle ready ----------------
    mem_ready = 1'b1;
    req(32'h047F_FFF8, 64'h0BAD_F00D_1234_5678, 1'b1);
    tick(); // cycle 1
    check("vw_mem_valid", 64'(mem_valid), 64'd1);
    check("vw_mem_sel", 64'(mem_sel), 64'd0);
    check("vw_mem_addr", 64'(mem_addr), 64'h7F_FFF8);
    check("vw_mem_wen", 64'(mem_wen), 64'd1);
    check("vw_mem_wdata", mem_wdata, 64'h0BAD_F00D_1234_5678);
    tick(); // cycle 2
    mem_ready = 1'b0;
    check("vw_resp_c2", 64'(dm_resp_valid), 64'd1);
    check("vw_mem_valid_c2", 64'(mem_valid), 64'd0);
    check("vw_no_err", 64'(err_unmapped), 64'd0);
    dm_req_valid = 1'b0;
    tick();

    // ---------------- timeout (TIMEOUT=4 instance) ----------------
    dm_req_addr    = 32'h0400_0008;
    dm_req_wen     = 1'b0;
    dm_req_valid_t = 1'b1;
    tick(); // cycle 1
    check("to_mem_valid_c1", 64'(mem_valid_t), 64'd1);
    check("to_mem_addr", 64'(mem_addr_t), 64'h00_0008);
    check("to_mem_sel", 64'(mem_sel_t), 64'd0);
    lat = 1;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (dm_resp_valid_t) begin
        lat = c;
        break;
      end
    end
    check("to_latency", 64'(lat), 64'd6);
    check("to_resp", 64'(dm_resp_valid_t), 64'd1);
    check("to_rdata", dm_resp_rdata_t, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_flag", 64'(err_timeout_t), 64'd1);
    check("to_err_addr", 64'(err_addr_t), 64'h0400_0008);
    check("to_mem_valid_drop", 64'(mem_valid_t), 64'd0);
    check("to_main_untouched", 64'(err_timeout), 64'd0);
    dm_req_valid_t = 1'b0;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555_5555_5555_5555;
    tick();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("to_late_rvalid", 64'(dm_resp_valid_t), 64'd0);
      tick();
    end
    check("to_rdata_held", dm_resp_rdata_t, 64'hFFFF_FFFF_FFFF_FFFF);

    // ---------------- reset during MEM_WAIT ----------------
    mem_ready = 1'b1;
    req(32'h0C00_0020, 64'd0, 1'b0);
    tick(); // cycle 1: accepted at the following edge
    check("rw_mem_valid_c1", 64'(mem_valid), 64'd1);
    tick(); // cycle 2: MEM_WAIT
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rw_mem_valid_rst", 64'(mem_valid), 64'd0);
    check("rw_resp_rst", 64'(dm_resp_valid), 64'd0);
    check("rw_rdata_rst", dm_resp_rdata, 64'd0);
    dm_req_valid = 1'b0;
    tick();
    check("rw_resp_hold", 64'(dm_resp_valid), 64'd0);
    check("rw_err_flags", 64'({err_unmapped, err_timeout}), 64'd0);
    rst = 1'b0;
    tick();
    check("rw_idle_resp", 64'(dm_resp_valid), 64'd0);
    check("rw_idle_mem_valid", 64'(mem_valid), 64'd0);

    mem_ready = 1'b1;
    req(32'h0C00_0100, 64'd0, 1'b0);
    tick(); // cycle 1
    check("rf_mem_valid", 64'(mem_valid), 64'd1);
    check("rf_mem_addr", 64'(mem_addr), 64'h00_0100);
    tick(); // cycle 2
    mem_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    check("rf_resp_c2", 64'(dm_resp_valid), 64'd0);
    tick(); // cycle 3
    mem_rvalid = 1'b0;
    check("rf_resp_c3", 64'(dm_resp_valid), 64'd1);
    check("rf_rdata", dm_resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    dm_req_valid = 1'b0;
    tick();
    check("rf_resp_once", 64'(dm_resp_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/holly_dm_responder.md
# holly_dm_responder

Target-side responder for the SH4 core data-memory request interface (`dm_req_*` / `dm_resp_*`). It captures one request at a time and decodes the 29-bit physical address. It routes the request to the PVR register port, to a 64-bit external memory port (VRAM and work SDRAM), or to an unmapped sink, and returns a single-cycle `dm_resp_valid` with read data. It sits between the core and `pvr`/memory models in the simulation top, replacing the direct `dm_resp_rdata` mux.

## Interface
- `TIMEOUT`, default 255: memory-port cycles allowed per request before a forced error response (8-bit counter).
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `dm_req_addr` in 32: request address; bits [28:0] decoded.
- `dm_req_wdata` in 64: write data.
- `dm_req_wmask` in 8: byte enables.
- `dm_req_wen` in 1: 1 = write.
- `dm_req_valid` in 1: request present; initiator holds it stable until `dm_resp_valid`.
- `dm_resp_rdata` out 64: read data; held until the next response.
- `dm_resp_valid` out 1: one-cycle completion pulse, for reads and writes.
- `pvr_reg_cs`, `pvr_rd`, `pvr_wr` out 1 each: PVR register strobes.
- `pvr_addr` out 16: address bits [15:0].
- `pvr_din` out 32: write lane.
- `pvr_dout` in 32: PVR read data, valid the cycle after `pvr_rd`.
- `mem_addr` out 24: byte offset within target.
- `mem_sel` out 1: 0 = VRAM, 1 = SDRAM.
- `mem_wdata` out 64, `mem_wmask` out 8, `mem_wen` out 1: write payload.
- `mem_valid` out 1, `mem_ready` in 1: request handshake.
- `mem_rdata` in 64, `mem_rvalid` in 1: read return.
- `err_clr` in 1: clears sticky errors.
- `err_unmapped` out 1, `err_timeout` out 1: sticky error flags.
- `err_addr` out 29: address of the most recent error.

## Operation
- Address regions (inclusive):
  - PVR regs 0x005F7C00–0x005F7CFF.
  - VRAM 0x04000000–0x047FFFFF, with `mem_sel`=0 and `mem_addr`=addr[22:0].
  - SDRAM 0x0C000000–0x0CFFFFFF, with `mem_sel`=1 and `mem_addr`=addr[23:0].
  - All other addresses are unmapped.
- FSM states: IDLE, PVR_STB, PVR_DATA, MEM_REQ, MEM_WAIT, RESP.
- IDLE: when `dm_req_valid`, register addr/wdata/wmask/wen and the decode result.
  - PVR region → PVR_STB.
  - VRAM or SDRAM → MEM_REQ.
  - Unmapped → RESP. Read data is 0; writes are discarded. Set `err_unmapped` and load `err_addr`.
- PVR_STB: for exactly this cycle, assert `pvr_reg_cs` and `pvr_rd` (read) or `pvr_wr` (write).
  - `pvr_din` = addr[2] ? wdata[63:32] : wdata[31:0].
  - Next state PVR_DATA.
- PVR_DATA: capture rdata = {`pvr_dout`, `pvr_dout`} for reads, then → RESP.
- MEM_REQ: `mem_valid`=1 with the payload stable until `mem_ready`.
  - On acceptance, a write → RESP and a read → MEM_WAIT.
- MEM_WAIT: on `mem_rvalid`, capture `mem_rdata` → RESP.
- Timeout: an 8-bit counter clears on leaving IDLE and increments each cycle in MEM_REQ/MEM_WAIT.
  - When count == `TIMEOUT` → RESP with rdata 64'hFFFF_FFFF_FFFF_FFFF.
  - Set `err_timeout` and load `err_addr`.
  - `mem_valid` drops in the same transition.
  - A late `mem_rvalid` after a timeout is ignored.
- RESP: `dm_resp_valid`=1 for one cycle, then → IDLE.
  - `dm_req_valid` is ignored in RESP, so a held request is never re-accepted.
- `err_clr` clears both flags. Simultaneous `err_clr` and a new error: the error wins.
- `mem_rvalid` or `mem_ready` outside their waiting states is ignored.

## Timing
- Reset values: state IDLE; every output 0 (`dm_resp_rdata`, `err_addr`, flags included).
- Reset mid-operation aborts the transaction immediately; `mem_valid` and the PVR strobes drop asynchronously.
- Latency from the cycle `dm_req_valid` is first sampled (cycle 0):
  - Unmapped: response in cycle 1.
  - PVR: response in cycle 3.
  - Memory write with same-cycle `mem_ready`: response in cycle 2.
  - Memory read with `mem_rvalid` in cycle k: response in cycle k+1.
- Back-to-back throughput: the next request is accepted no earlier than the cycle after `dm_resp_valid`.
- All outputs are registered or decoded from registered state only; there is no combinational path from the `dm_req_*` inputs.

## Structure
- Package `holly_pkg`:
  - Region base/limit localparams (PVR, VRAM, SDRAM).
  - State enum.
  - Region-select enum (PVR, VRAM, SDRAM, UNMAPPED).
  - Error fill constant 64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module `holly_addr_decode`: combinational, 29-bit address in → region select + 24-bit offset. It is reused by the later TA-FIFO path.

## Test plan
- Read 0x005F7C40 with `pvr_dout`=0x12345678 → `pvr_rd` pulses in cycle 1 with `pvr_addr`=0x7C40; response in cycle 3 with rdata 0x12345678_12345678.
- Write 0x005F7C44, wdata 0xAAAA0000_55550000 → one `pvr_wr` pulse with `pvr_din`=0xAAAA0000; `dm_resp_valid` in cycle 3.
- Read 0x0C001000 with `mem_ready` delayed 3 cycles and `mem_rvalid` 2 cycles later with 0x0123456789ABCDEF → `mem_sel`=1, `mem_addr`=0x001000; response returns that data; no second `mem_valid`.
- Read 0x1F000000 → response in cycle 1 with rdata 0; `err_unmapped`=1, `err_addr`=0x1F000000; pulse `err_clr` → flag clears.
- Read 0x04000008 with `TIMEOUT`=4 and `mem_ready` never asserted → response with all-ones rdata; `err_timeout`=1; a late `mem_rvalid` produces no response.
- Assert `rst` during MEM_WAIT → `mem_valid` and `dm_resp_valid` stay 0; after release, a fresh SDRAM read completes normally.
